wb_dbg_master: RTL and testbench

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

---
 rtl/wb_dbg_pkg.sv | 23 ++
 rtl/wb_dbg_master.sv | 180 ++++++++++++++++++
 tb/tb_wb_dbg_master.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dbg_pkg.sv
// Shared state encoding and protocol byte constants for the UART-driven Wishbone debug master.
package wb_dbg_pkg;

   typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   // Byte idx of a word, MSB first (idx 0 is bits 31:24).
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      unique case (idx)
         2'd0: b = w[31:24];
         2'd1: b = w[23:16];
         2'd2: b = w[15:8];
         2'd3: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/wb_dbg_master.sv
// UART byte-stream to Wishbone debug master: 'W' addr[4] data[4] / 'R' addr[4] commands.
// Define WB_DBG_TIMEOUT_EN to abort bus cycles that see no ack/err within TIMEOUT cycles.
module wb_dbg_master
   import wb_dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] rdata_q, rdata_d;
   logic        cmd_we_q, cmd_we_d;
   logic        bus_q, bus_d;
   logic        multi_q, multi_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        timeout;

`ifdef WB_DBG_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = '0;
      if (bus_q) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
   end

   assign timeout = bus_q && (tmo_cnt_q == TmoW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end
`else
   // TIMEOUT is accepted but has no effect: the bus waits indefinitely.
   assign timeout = (TIMEOUT == 0) & 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rdata_d    = rdata_q;
      cmd_we_d   = cmd_we_q;
      bus_d      = bus_q;
      multi_d    = multi_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      unique case (state_q)
         StIdle: begin
            if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
               cmd_we_d = (rx_data == CMD_WR);
               state_d  = StAddr;
            end
         end
         StAddr: begin
            if (rx_valid) begin
               addr_d = {addr_q[23:0], rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  if (cmd_we_q) begin
                     state_d = StData;
                  end else begin
                     state_d = StBus;
                     bus_d   = 1'b1;
                  end
               end
            end
         end
         StData: begin
            if (rx_valid) begin
               data_d = {data_q[23:0], rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = StBus;
                  bus_d   = 1'b1;
               end
            end
         end
         StBus: begin
            if (wb_err_i || wb_ack_i || timeout) begin
               bus_d      = 1'b0;
               state_d    = StResp;
               tx_valid_d = 1'b1;
               cnt_d      = 2'd0;
               // err wins over a simultaneous ack; a bare timeout is also an error
               if (wb_err_i || !wb_ack_i) begin
                  tx_data_d = RSP_ERR;
                  multi_d   = 1'b0;
               end else if (cmd_we_q) begin
                  tx_data_d = RSP_OK;
                  multi_d   = 1'b0;
               end else begin
                  rdata_d   = wb_dat_i;
                  tx_data_d = wb_dat_i[31:24];
                  multi_d   = 1'b1;
               end
            end
         end
         StResp: begin
            if (tx_valid_q && tx_ready) begin
               if (multi_q && cnt_q != 2'd3) begin
                  cnt_d     = cnt_q + 2'd1;
                  tx_data_d = word_byte(rdata_q, cnt_q + 2'd1);
               end else begin
                  cnt_d      = 2'd0;
                  tx_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rdata_q    <= '0;
         cmd_we_q   <= 1'b0;
         bus_q      <= 1'b0;
         multi_q    <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rdata_q    <= rdata_d;
         cmd_we_q   <= cmd_we_d;
         bus_q      <= bus_d;
         multi_q    <= multi_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign wb_adr_o = {addr_q[31:2], 2'b00};
   assign wb_dat_o = data_q;
   assign wb_sel_o = {4{bus_q}};
   assign wb_we_o  = bus_q & cmd_we_q;
   assign wb_cyc_o = bus_q;
   assign wb_stb_o = bus_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Scoreboard bench for wb_dbg_master: expected tx bytes and bus cycles are queued as commands are sent.
module tb_wb_dbg_master;

   localparam int unsigned Tmo = 8;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
      logic [3:0]  sel;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, busy;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   logic [7:0]  exp_tx[$];
   logic [7:0]  tx_got[$];
   bus_t        exp_bus[$];
   bus_t        bus_got[$];
   int          tx_rd = 0;
   int          bus_rd = 0;
   int          cyc_cycles = 0;
   int          hold_viol = 0;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_data = '0;
   int          errors = 0;
   int          checks = 0;
   int          slave_mode = 0;  // 0 ack, 1 ack+err, 2 never respond
   int          slave_delay = 0;
   int          slv_cnt = 0;
   logic [31:0] slave_rdata = '0;
   int          ready_mode = 0;  // 0 high, 1 toggling, 2 low

   always #5 clk = ~clk;

   wb_dbg_master #(.TIMEOUT(Tmo)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i),
      .busy     (busy)
   );

   assign wb_dat_i = slave_rdata;

   // Slave: responds once the strobe has been high for slave_delay+1 cycles.
   always @(negedge clk) begin
      if (wb_cyc_o && wb_stb_o && !rst) begin
         slv_cnt  = slv_cnt + 1;
         wb_ack_i = (slave_mode != 2) && (slv_cnt == slave_delay + 1);
         wb_err_i = (slave_mode == 1) && (slv_cnt == slave_delay + 1);
      end else begin
         slv_cnt  = 0;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (ready_mode == 0)      tx_ready = 1'b1;
      else if (ready_mode == 1) tx_ready = ~tx_ready;
      else                      tx_ready = 1'b0;
   end

   always @(posedge clk) begin
      if (tx_valid && tx_ready) tx_got.push_back(tx_data);
      if (hold_pend && (!tx_valid || tx_data !== hold_data)) hold_viol = hold_viol + 1;
      hold_pend = tx_valid && !tx_ready && !rst;
      hold_data = tx_data;
      if (wb_cyc_o) cyc_cycles = cyc_cycles + 1;
      if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i))
         bus_got.push_back({wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o});
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while ((tx_got.size() - tx_rd) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
         errors++; $display("FAIL reset_cyc_stb_we: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o});
      end
      checks++;
      if (wb_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", wb_sel_o); end
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      checks++;
      if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
         errors++; $display("FAIL reset_adr_dat: got %h %h want 0 0", wb_adr_o, wb_dat_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write;
      logic [7:0] cmd [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      int c0;
      bus_t eb, gb;
      logic [7:0] et;
      ready_mode = 0; slave_mode = 0; slave_delay = 2;
      exp_tx.push_back(8'h4B);
      exp_bus.push_back('{adr: 32'h0000_0010, dat: 32'hDEAD_BEEF, we: 1'b1, sel: 4'hF});
      c0 = cyc_cycles;
      for (int i = 0; i < 8; i++) send_byte(cmd[i]);
      checks++;
      if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL write_cyc_early: got %b want 0", wb_cyc_o); end
      send_byte(cmd[8]);
      checks++;
      if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL write_cyc_latency: got %b want 1", wb_cyc_o); end
      wait_tx(1, 50);
      idle(3);
      checks++;
      if (cyc_cycles - c0 != 3) begin
         errors++; $display("FAIL write_cyc_len: got %0d want 3", cyc_cycles - c0);
      end
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (bus_rd >= bus_got.size()) begin
            errors++; $display("FAIL write_bus: got none want adr=%h", eb.adr);
         end else begin
            gb = bus_got[bus_rd]; bus_rd++;
            if (gb !== eb) begin
               errors++;
               $display("FAIL write_bus: got adr=%h dat=%h we=%b sel=%h want adr=%h dat=%h we=%b sel=%h",
                        gb.adr, gb.dat, gb.we, gb.sel, eb.adr, eb.dat, eb.we, eb.sel);
            end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (tx_rd >= tx_got.size()) begin
            errors++; $display("FAIL write_tx: got none want %h", et);
         end else begin
            if (tx_got[tx_rd] !== et) begin
               errors++; $display("FAIL write_tx: got %h want %h", tx_got[tx_rd], et);
            end
            tx_rd++;
         end
      end
      checks++;
      if (tx_got.size() != tx_rd || busy !== 1'b0) begin
         errors++; $display("FAIL write_tail: got extra=%0d busy=%b want 0 0", tx_got.size() - tx_rd, busy);
      end
   endtask

   task automatic test_read;
      logic [7:0] cmd [5] = '{8'h52, 8'h70, 8'h00, 8'h00, 8'h03};
      logic [7:0] rb [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      int h0;
      bus_t eb, gb;
      logic [7:0] et;
      ready_mode = 1; slave_mode = 0; slave_delay = 1; slave_rdata = 32'h1234_5678;
      h0 = hold_viol;
      for (int i = 0; i < 4; i++) exp_tx.push_back(rb[i]);
      exp_bus.push_back('{adr: 32'h7000_0000, dat: 32'h0, we: 1'b0, sel: 4'hF});
      for (int i = 0; i < 5; i++) send_byte(cmd[i]);
      wait_tx(4, 60);
      idle(4);
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (bus_rd >= bus_got.size()) begin
            errors++; $display("FAIL read_bus: got none want adr=%h", eb.adr);
         end else begin
            gb = bus_got[bus_rd]; bus_rd++;
            if (gb.adr !== eb.adr || gb.we !== eb.we || gb.sel !== eb.sel) begin
               errors++;
               $display("FAIL read_bus: got adr=%h we=%b sel=%h want adr=%h we=%b sel=%h",
                        gb.adr, gb.we, gb.sel, eb.adr, eb.we, eb.sel);
            end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (tx_rd >= tx_got.size()) begin
            errors++; $display("FAIL read_tx: got none want %h", et);
         end else begin
            if (tx_got[tx_rd] !== et) begin
               errors++; $display("FAIL read_tx: got %h want %h", tx_got[tx_rd], et);
            end
            tx_rd++;
         end
      end
      checks++;
      if (hold_viol != h0) begin
         errors++; $display("FAIL read_tx_hold: got %0d violations want 0", hold_viol - h0);
      end
      checks++;
      if (tx_got.size() != tx_rd || busy !== 1'b0) begin
         errors++; $display("FAIL read_tail: got extra=%0d busy=%b want 0 0", tx_got.size() - tx_rd, busy);
      end
      ready_mode = 0;
   endtask

   task automatic test_error;
      logic [7:0] rd [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04};
      logic [7:0] wr [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      bus_t eb, gb;
      logic [7:0] et;
      ready_mode = 0; slave_mode = 1; slave_delay = 0;
      exp_tx.push_back(8'h45);
      exp_bus.push_back('{adr: 32'h0000_0004, dat: 32'h0, we: 1'b0, sel: 4'hF});
      for (int i = 0; i < 5; i++) send_byte(rd[i]);
      wait_tx(1, 40);
      idle(6);
      checks++;
      if (tx_got.size() - tx_rd != 1) begin
         errors++; $display("FAIL error_tx_count: got %0d want 1", tx_got.size() - tx_rd);
      end
      slave_mode = 0; slave_delay = 1;
      exp_tx.push_back(8'h4B);
      exp_bus.push_back('{adr: 32'h0000_0020, dat: 32'hCAFE_F00D, we: 1'b1, sel: 4'hF});
      for (int i = 0; i < 9; i++) send_byte(wr[i]);
      wait_tx(2, 40);
      idle(3);
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (bus_rd >= bus_got.size()) begin
            errors++; $display("FAIL error_bus: got none want adr=%h", eb.adr);
         end else begin
            gb = bus_got[bus_rd]; bus_rd++;
            if (gb.adr !== eb.adr || gb.we !== eb.we || gb.sel !== eb.sel || (eb.we && gb.dat !== eb.dat)) begin
               errors++;
               $display("FAIL error_bus: got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                        gb.adr, gb.dat, gb.we, eb.adr, eb.dat, eb.we);
            end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (tx_rd >= tx_got.size()) begin
            errors++; $display("FAIL error_tx: got none want %h", et);
         end else begin
            if (tx_got[tx_rd] !== et) begin
               errors++; $display("FAIL error_tx: got %h want %h", tx_got[tx_rd], et);
            end
            tx_rd++;
         end
      end
   endtask

   task automatic test_reset_mid_bus;
      logic [7:0] rd [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
      slave_mode = 2;
      for (int i = 0; i < 5; i++) send_byte(rd[i]);
      idle(3);
      checks++;
      if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstbus_cyc_before: got %b want 1", wb_cyc_o); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         errors++; $display("FAIL rstbus_cyc_drop: got %b%b want 00", wb_cyc_o, wb_stb_o);
      end
      @(negedge clk);
      rst = 1'b0;
      idle(5);
      checks++;
      if (tx_got.size() != tx_rd || busy !== 1'b0) begin
         errors++; $display("FAIL rstbus_tail: got tx=%0d busy=%b want 0 0", tx_got.size() - tx_rd, busy);
      end
      slave_mode = 0;
   endtask

   task automatic test_timeout;
      logic [7:0] rd [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
      int c0;
      slave_mode = 2;
      c0 = cyc_cycles;
      for (int i = 0; i < 5; i++) send_byte(rd[i]);
`ifdef WB_DBG_TIMEOUT_EN
      wait_tx(1, 40);
      idle(3);
      checks++;
      if (cyc_cycles - c0 != Tmo) begin
         errors++; $display("FAIL timeout_len: got %0d want %0d", cyc_cycles - c0, Tmo);
      end
      checks++;
      if (tx_rd >= tx_got.size()) begin
         errors++; $display("FAIL timeout_tx: got none want 45");
      end else begin
         if (tx_got[tx_rd] !== 8'h45) begin
            errors++; $display("FAIL timeout_tx: got %h want 45", tx_got[tx_rd]);
         end
         tx_rd++;
      end
`else
      idle(1000);
      checks++;
      if (wb_cyc_o !== 1'b1 || cyc_cycles - c0 < 1000) begin
         errors++; $display("FAIL notimeout_cyc: got %b after %0d want 1", wb_cyc_o, cyc_cycles - c0);
      end
      checks++;
      if (tx_got.size() != tx_rd) begin
         errors++; $display("FAIL notimeout_tx: got %0d bytes want 0", tx_got.size() - tx_rd);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
`endif
      slave_mode = 0;
   endtask

   task automatic test_junk_reset;
      int c0;
      c0 = cyc_cycles;
      send_byte(8'h00);
      send_byte(8'hFF);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL junk_busy: got %b want 0", busy); end
      send_byte(8'h52);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL junk_decode: got %b want 1", busy); end
      send_byte(8'h70);
      send_byte(8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL junk_rst_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      idle(8);
      checks++;
      if (cyc_cycles != c0 || tx_got.size() != tx_rd) begin
         errors++; $display("FAIL junk_quiet: got cyc=%0d tx=%0d want 0 0", cyc_cycles - c0, tx_got.size() - tx_rd);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] rd [5] = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
      logic [7:0] wr [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
      logic [7:0] rb [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      int h0;
      bus_t eb, gb;
      logic [7:0] et;
      ready_mode = 2; slave_mode = 0; slave_delay = 3; slave_rdata = 32'hA1B2_C3D4;
      h0 = hold_viol;
      for (int i = 0; i < 4; i++) exp_tx.push_back(rb[i]);
      exp_bus.push_back('{adr: 32'h0000_0100, dat: 32'h0, we: 1'b0, sel: 4'hF});
      for (int i = 0; i < 5; i++) send_byte(rd[i]);
      send_byte(8'h57);
      send_byte(8'h52);
      idle(6);
      send_byte(8'h57);
      send_byte(8'h00);
      checks++;
      if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
         errors++; $display("FAIL overrun_hold: got busy=%b v=%b d=%h want 1 1 a1", busy, tx_valid, tx_data);
      end
      ready_mode = 0;
      wait_tx(4, 40);
      idle(3);
      exp_tx.push_back(8'h4B);
      exp_bus.push_back('{adr: 32'h0000_0040, dat: 32'h0102_0304, we: 1'b1, sel: 4'hF});
      for (int i = 0; i < 9; i++) send_byte(wr[i]);
      wait_tx(5, 40);
      idle(3);
      while (exp_bus.size() > 0) begin
         eb = exp_bus.pop_front();
         checks++;
         if (bus_rd >= bus_got.size()) begin
            errors++; $display("FAIL overrun_bus: got none want adr=%h", eb.adr);
         end else begin
            gb = bus_got[bus_rd]; bus_rd++;
            if (gb.adr !== eb.adr || gb.we !== eb.we || gb.sel !== eb.sel || (eb.we && gb.dat !== eb.dat)) begin
               errors++;
               $display("FAIL overrun_bus: got adr=%h dat=%h we=%b want adr=%h dat=%h we=%b",
                        gb.adr, gb.dat, gb.we, eb.adr, eb.dat, eb.we);
            end
         end
      end
      while (exp_tx.size() > 0) begin
         et = exp_tx.pop_front();
         checks++;
         if (tx_rd >= tx_got.size()) begin
            errors++; $display("FAIL overrun_tx: got none want %h", et);
         end else begin
            if (tx_got[tx_rd] !== et) begin
               errors++; $display("FAIL overrun_tx: got %h want %h", tx_got[tx_rd], et);
            end
            tx_rd++;
         end
      end
      checks++;
      if (bus_got.size() != bus_rd || tx_got.size() != tx_rd || hold_viol != h0) begin
         errors++;
         $display("FAIL overrun_tail: got bus=%0d tx=%0d hold=%0d want 0 0 0",
                  bus_got.size() - bus_rd, tx_got.size() - tx_rd, hold_viol - h0);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_error();
      test_reset_mid_bus();
      test_timeout();
      test_junk_reset();
      test_overrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion want finish within 1ms");
      $fatal(1, "watchdog expired");
   end

endmodule
